// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: it synchronises and deglitches the PS/2 lines,
// deserialises odd-parity frames and folds the F0/E0 prefixes into flags on a sticky key_ready.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_ready,
    output logic       key_release,
    output logic       key_ext,
    output logic       overrun,
    output logic       frame_err
);

    // state  | meaning
    // IDLE   | waiting for a start bit (data low on a clock fall)
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the parity bit and computing the odd-parity result
    // STOP   | checking the stop bit, then delivering the byte
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [1:0]    clk_sync, data_sync;
    logic [FW-1:0] clk_cnt, data_cnt;
    logic          clk_filt, data_filt, clk_filt_q;
    logic          fall;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_ok;
    logic [TW-1:0] tmr;
    logic          timeout;
    logic          deliver, err;
    logic          rel_pend, ext_pend;
    logic          is_prefix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // A filtered line only follows the synchronised input after FILTER_LEN
    // consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt  <= '0;
            clk_filt <= 1'b1;
        end else if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
        end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_cnt  <= '0;
            data_filt <= 1'b1;
        end else if (data_sync[1] == data_filt) begin
            data_cnt <= '0;
        end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
            data_filt <= data_sync[1];
            data_cnt  <= '0;
        end else begin
            data_cnt <= data_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clk_filt_q <= 1'b1;
        else     clk_filt_q <= clk_filt;
    end

    assign fall    = clk_filt_q & ~clk_filt;
    assign timeout = (state != IDLE) && !fall && (tmr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall && !data_filt)        state_nxt = DATA;
            DATA:    if (fall && bit_cnt == 3'd7)   state_nxt = PARITY;
            PARITY:  if (fall)                      state_nxt = STOP;
            STOP:    if (fall)                      state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_comb begin
        deliver = (state == STOP) && fall && data_filt && par_ok;
        err     = timeout
                | ((state == IDLE) && fall && data_filt)
                | ((state == STOP) && fall && !(data_filt && par_ok));
    end

    // Timeout down-counter: reloaded on every fall (and while idle), aborts
    // the frame when it runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_ok  <= 1'b0;
            tmr     <= TW'(TIMEOUT);
        end else begin
            if (fall || state == IDLE) tmr <= TW'(TIMEOUT);
            else if (tmr != '0)        tmr <= tmr - 1'b1;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift   <= {data_filt, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_ok <= ^{shift, data_filt};
                    default: ;
                endcase
            end
        end
    end

    assign is_prefix = (shift == 8'hF0) || (shift == 8'hE0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code    <= '0;
            key_ready   <= 1'b0;
            key_release <= 1'b0;
            key_ext     <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
            rel_pend    <= 1'b0;
            ext_pend    <= 1'b0;
        end else begin
            frame_err <= err;
            if (key_ack && key_ready) begin
                key_ready <= 1'b0;
                overrun   <= 1'b0;
            end
            if (deliver) begin
                if (shift == 8'hF0) rel_pend <= 1'b1;
                if (shift == 8'hE0) ext_pend <= 1'b1;
                if (!is_prefix) begin
                    key_code    <= shift;
                    key_release <= rel_pend;
                    key_ext     <= ext_pend;
                    key_ready   <= 1'b1;
                    // A simultaneous ack consumes the old byte, so nothing is lost.
                    overrun     <= key_ack ? 1'b0 : (overrun | key_ready);
                    rel_pend    <= 1'b0;
                    ext_pend    <= 1'b0;
                end
            end
        end
    end

endmodule
